digit_entry_register: RTL and testbench

DIGIT_ENTRY_REGISTER -- requirements
Module: digit_entry_register

---
 rtl/microwave_pkg.sv | 14 +
 rtl/rise_edge_detect.sv | 19 +
 rtl/digit_entry_register.sv | 131 +++++++++++++
 tb/tb_digit_entry_register.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/microwave_pkg.sv
// rtl/microwave_pkg.sv - shared constants and state encoding for the keypad time entry
package microwave_pkg;

  localparam int DEF_NUM_DIGITS   = 4;
  localparam int DEF_MAX_SEC_TENS = 5;
  localparam int BCD_W            = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENTRY = 2'd1,
    ST_LOAD  = 2'd2
  } entry_state_t;

endpackage

// File: rtl/rise_edge_detect.sv
// rtl/rise_edge_detect.sv - rising-edge pulse for a level key input
module rise_edge_detect (
  input  logic clk,
  input  logic resetn,
  input  logic i_sig,
  output logic o_rise
);

  logic r_prev;

  // Previous value resets high so a key held through reset is not seen as a press.
  always_ff @(posedge clk) begin
    if (!resetn) r_prev <= 1'b1;
    else         r_prev <= i_sig;
  end

  assign o_rise = i_sig & ~r_prev;

endmodule

// File: rtl/digit_entry_register.sv
// rtl/digit_entry_register.sv - MM:SS digit entry with start validation and timer load handshake
module digit_entry_register
  import microwave_pkg::*;
#(
  parameter int NUM_DIGITS   = DEF_NUM_DIGITS,
  parameter int MAX_SEC_TENS = DEF_MAX_SEC_TENS
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [BCD_W-1:0]              bcd_in,
  input  logic                          key_valid,
  input  logic                          clear,
  input  logic                          start,
  input  logic                          load_ready,
  output logic [BCD_W*NUM_DIGITS-1:0]   digits,
  output logic [2:0]                    digit_count,
  output logic                          load_valid,
  output logic                          entry_err
);

  localparam int DW = BCD_W * NUM_DIGITS;

  entry_state_t    r_state, w_next_state;
  logic [DW-1:0]   r_digits, w_next_digits;
  logic [2:0]      r_count, w_next_count;
  logic            r_load_valid, w_next_load_valid;
  logic            r_entry_err, w_next_entry_err;

  logic            w_key_rise, w_clear_rise, w_start_rise;
  logic            w_key_accept;
  logic [BCD_W-1:0] w_sec_tens;

  rise_edge_detect u_key_edge (
    .clk    (clk),
    .resetn (resetn),
    .i_sig  (key_valid),
    .o_rise (w_key_rise)
  );

  rise_edge_detect u_clear_edge (
    .clk    (clk),
    .resetn (resetn),
    .i_sig  (clear),
    .o_rise (w_clear_rise)
  );

  rise_edge_detect u_start_edge (
    .clk    (clk),
    .resetn (resetn),
    .i_sig  (start),
    .o_rise (w_start_rise)
  );

  assign w_key_accept = w_key_rise && (r_count < 3'(NUM_DIGITS)) && (bcd_in <= 4'd9);
  assign w_sec_tens   = r_digits[2*BCD_W-1:BCD_W];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state      <= ST_IDLE;
      r_digits     <= '0;
      r_count      <= '0;
      r_load_valid <= 1'b0;
      r_entry_err  <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_digits     <= w_next_digits;
      r_count      <= w_next_count;
      r_load_valid <= w_next_load_valid;
      r_entry_err  <= w_next_entry_err;
    end
  end

  // Priority: clear, then start, then digit key.
  always_comb begin
    w_next_state      = r_state;
    w_next_digits     = r_digits;
    w_next_count      = r_count;
    w_next_load_valid = r_load_valid;
    w_next_entry_err  = 1'b0;

    if (w_clear_rise) begin
      w_next_state      = ST_IDLE;
      w_next_digits     = '0;
      w_next_count      = '0;
      w_next_load_valid = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_key_accept) begin
            w_next_digits = {r_digits[DW-BCD_W-1:0], bcd_in};
            w_next_count  = r_count + 3'd1;
            w_next_state  = ST_ENTRY;
          end
        end
        ST_ENTRY: begin
          if (w_start_rise) begin
            if (w_sec_tens <= 4'(MAX_SEC_TENS)) begin
              w_next_state      = ST_LOAD;
              w_next_load_valid = 1'b1;
            end else begin
              w_next_entry_err  = 1'b1;
            end
          end else if (w_key_accept) begin
            w_next_digits = {r_digits[DW-BCD_W-1:0], bcd_in};
            w_next_count  = r_count + 3'd1;
          end
        end
        ST_LOAD: begin
          if (r_load_valid && load_ready) begin
            w_next_state      = ST_IDLE;
            w_next_digits     = '0;
            w_next_count      = '0;
            w_next_load_valid = 1'b0;
          end
        end
        default: begin
          w_next_state      = ST_IDLE;
          w_next_digits     = '0;
          w_next_count      = '0;
          w_next_load_valid = 1'b0;
        end
      endcase
    end
  end

  assign digits      = r_digits;
  assign digit_count = r_count;
  assign load_valid  = r_load_valid;
  assign entry_err   = r_entry_err;

endmodule

// File: tb/tb_digit_entry_register.sv
// tb/tb_digit_entry_register.sv - self-checking bench for digit_entry_register
module tb_digit_entry_register;

  logic        clk = 1'b0;
  logic        resetn;
  logic [3:0]  bcd_in;
  logic        key_valid, clear, start, load_ready;
  logic [15:0] digits;
  logic [2:0]  digit_count;
  logic        load_valid, entry_err;

  int checks = 0;
  int errors = 0;

  // Reference: list of entered digits, a loading flag and an error pulse.
  int m_q[$];
  bit m_load, m_err;
  bit m_pk, m_pc, m_ps;

  always #5 clk = ~clk;

  digit_entry_register dut (
    .clk         (clk),
    .resetn      (resetn),
    .bcd_in      (bcd_in),
    .key_valid   (key_valid),
    .clear       (clear),
    .start       (start),
    .load_ready  (load_ready),
    .digits      (digits),
    .digit_count (digit_count),
    .load_valid  (load_valid),
    .entry_err   (entry_err)
  );

  function automatic logic [15:0] m_value();
    int v = 0;
    foreach (m_q[i]) v = v * 16 + m_q[i];
    return 16'(v);
  endfunction

  task automatic model_update();
    bit kr, cr, sr;
    int tens;
    if (!resetn) begin
      m_q.delete();
      m_load = 0; m_err = 0;
      m_pk = 1; m_pc = 1; m_ps = 1;
      return;
    end
    kr = key_valid && !m_pk;
    cr = clear && !m_pc;
    sr = start && !m_ps;
    m_err = 0;
    if (cr) begin
      m_q.delete();
      m_load = 0;
    end else if (m_load) begin
      if (load_ready) begin
        m_q.delete();
        m_load = 0;
      end
    end else if (sr && m_q.size() > 0) begin
      tens = (m_q.size() >= 2) ? m_q[m_q.size()-2] : 0;
      if (tens <= 5) m_load = 1;
      else           m_err = 1;
    end else if (kr && m_q.size() < 4 && bcd_in <= 9) begin
      m_q.push_back(int'(bcd_in));
    end
    m_pk = key_valid; m_pc = clear; m_ps = start;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic press(input logic [3:0] d);
    bcd_in = d; key_valid = 1'b1;
    step();
    key_valid = 1'b0;
    step();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    step();
  endtask

  task automatic test_reset();
    resetn = 1'b0; bcd_in = 4'd3; key_valid = 1'b1;
    clear = 1'b0; start = 1'b0; load_ready = 1'b0;
    step(); step();
    checks++;
    if (digits !== 16'h0 || digit_count !== 3'd0 || load_valid !== 1'b0 || entry_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state digits=%h count=%0d lv=%b err=%b required 0000/0/0/0",
               digits, digit_count, load_valid, entry_err);
    end
    resetn = 1'b1;
    step();
    checks++;
    if (digit_count !== 3'd0) begin
      errors++;
      $display("FAIL key_held_through_reset count=%0d required 0", digit_count);
    end
    key_valid = 1'b0;
    step();
  endtask

  task automatic test_entry();
    do_clear();
    bcd_in = 4'd1; key_valid = 1'b1;
    step();
    checks++;
    if (digits !== 16'h0001 || digit_count !== 3'd1) begin
      errors++;
      $display("FAIL first_key_latency digits=%h count=%0d required 0001/1", digits, digit_count);
    end
    key_valid = 1'b0;
    step();
    press(4'd2); press(4'd3); press(4'd0);
    checks++;
    if (digits !== 16'h1230 || digit_count !== 3'd4 || load_valid !== 1'b0) begin
      errors++;
      $display("FAIL four_keys digits=%h count=%0d lv=%b required 1230/4/0", digits, digit_count, load_valid);
    end
    press(4'd7);
    checks++;
    if (digits !== 16'h1230 || digit_count !== 3'd4) begin
      errors++;
      $display("FAIL fifth_key digits=%h count=%0d required 1230/4", digits, digit_count);
    end
  endtask

  task automatic test_bad_digit();
    do_clear();
    press(4'd4); press(4'hC);
    checks++;
    if (digits !== 16'h0004 || digit_count !== 3'd1) begin
      errors++;
      $display("FAIL non_bcd_key digits=%h count=%0d required 0004/1", digits, digit_count);
    end
  endtask

  task automatic test_bad_start();
    do_clear();
    press(4'd1); press(4'd7); press(4'd5);
    start = 1'b1;
    step();
    checks++;
    if (entry_err !== 1'b1 || load_valid !== 1'b0) begin
      errors++;
      $display("FAIL bad_start_pulse err=%b lv=%b required 1/0", entry_err, load_valid);
    end
    start = 1'b0;
    step();
    checks++;
    if (entry_err !== 1'b0 || digits !== 16'h0175 || load_valid !== 1'b0 || digit_count !== 3'd3) begin
      errors++;
      $display("FAIL bad_start_after err=%b digits=%h lv=%b count=%0d required 0/0175/0/3",
               entry_err, digits, load_valid, digit_count);
    end
  endtask

  task automatic test_load_handshake();
    int held = 0;
    do_clear();
    press(4'd1); press(4'd3); press(4'd0);
    load_ready = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (load_valid !== 1'b1 || digits !== 16'h0130) begin
        errors++;
        $display("FAIL load_hold cycle=%0d lv=%b digits=%h required 1/0130", i, load_valid, digits);
      end
      if (load_valid === 1'b1) held++;
      step();
    end
    load_ready = 1'b1;
    if (load_valid === 1'b1) held++;
    step();
    load_ready = 1'b0;
    checks++;
    if (held !== 4) begin
      errors++;
      $display("FAIL load_held_cycles got=%0d required 4", held);
    end
    checks++;
    if (load_valid !== 1'b0 || digits !== 16'h0 || digit_count !== 3'd0) begin
      errors++;
      $display("FAIL load_done lv=%b digits=%h count=%0d required 0/0000/0", load_valid, digits, digit_count);
    end
    press(4'd8);
    checks++;
    if (digits !== 16'h0008 || digit_count !== 3'd1) begin
      errors++;
      $display("FAIL idle_after_load digits=%h count=%0d required 0008/1", digits, digit_count);
    end
  endtask

  task automatic test_clear_priority();
    do_clear();
    press(4'd4); press(4'd5);
    clear = 1'b1; key_valid = 1'b1; bcd_in = 4'd9;
    step();
    clear = 1'b0; key_valid = 1'b0;
    checks++;
    if (digits !== 16'h0 || digit_count !== 3'd0) begin
      errors++;
      $display("FAIL clear_over_key digits=%h count=%0d required 0000/0", digits, digit_count);
    end
    step();
  endtask

  task automatic test_reset_in_load();
    do_clear();
    press(4'd1); press(4'd2);
    load_ready = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (load_valid !== 1'b1) begin
      errors++;
      $display("FAIL enter_load lv=%b required 1", load_valid);
    end
    resetn = 1'b0; load_ready = 1'b1;
    step();
    checks++;
    if (load_valid !== 1'b0 || digits !== 16'h0 || digit_count !== 3'd0) begin
      errors++;
      $display("FAIL reset_in_load lv=%b digits=%h count=%0d required 0/0000/0", load_valid, digits, digit_count);
    end
    resetn = 1'b1; load_ready = 1'b0;
    step();
    press(4'd6);
    checks++;
    if (digits !== 16'h0006 || digit_count !== 3'd1) begin
      errors++;
      $display("FAIL idle_after_reset digits=%h count=%0d required 0006/1", digits, digit_count);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      resetn     = ($urandom_range(0, 199) != 0);
      key_valid  = ($urandom_range(0, 2) == 0);
      bcd_in     = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      clear      = ($urandom_range(0, 29) == 0);
      start      = ($urandom_range(0, 7) == 0);
      load_ready = ($urandom_range(0, 2) == 0);
      step();
      checks++;
      if (digits !== m_value() || digit_count !== 3'(m_q.size()) ||
          load_valid !== m_load || entry_err !== m_err) begin
        errors++;
        $display("FAIL random cycle=%0d digits=%h count=%0d lv=%b err=%b required %h/%0d/%b/%b",
                 c, digits, digit_count, load_valid, entry_err,
                 m_value(), m_q.size(), m_load, m_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_entry();
    test_bad_digit();
    test_bad_start();
    test_load_handshake();
    test_clear_priority();
    test_reset_in_load();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
